// File: rtl/leb128_decoder.sv
// LEB128 immediate decoder: assembles u32/s32/s64/u64 immediates from a byte stream,
// one byte per handshake, and flags over-long or out-of-range encodings.
module leb128_decoder (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  mode,
  input  logic [7:0]  byte_in,
  input  logic        byte_valid,
  output logic        byte_ready,
  output logic        busy,
  output logic        done,
  output logic [63:0] value,
  output logic [3:0]  length,
  output logic [1:0]  error
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_DECODE = 2'd1;
  localparam logic [1:0] S_FINISH = 2'd2;

  localparam logic [1:0] M_U32 = 2'd0;
  localparam logic [1:0] M_S32 = 2'd1;
  localparam logic [1:0] M_S64 = 2'd2;
  localparam logic [1:0] M_U64 = 2'd3;

  localparam logic [1:0] E_OK    = 2'd0;
  localparam logic [1:0] E_LONG  = 2'd1;
  localparam logic [1:0] E_RANGE = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [1:0]  mode_q, mode_d;
  logic [63:0] acc_q, acc_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [63:0] value_q, value_d;
  logic [3:0]  length_q, length_d;
  logic [1:0]  error_q, error_d;

  logic [6:0]  payload;
  logic        cont;
  logic [3:0]  cnt_inc;
  logic [3:0]  max_len;
  logic        at_max;
  logic        is_signed;
  logic [6:0]  sh_cur;
  logic [6:0]  sh_new;
  logic [63:0] acc_new;
  logic [63:0] fill;
  logic [63:0] acc_ext;
  logic [63:0] result;
  logic [1:0]  err_new;

  always_comb begin
    payload   = byte_in[6:0];
    cont      = byte_in[7];
    cnt_inc   = cnt_q + 4'd1;
    max_len   = mode_q[1] ? 4'd10 : 4'd5;
    at_max    = (cnt_inc == max_len);
    is_signed = (mode_q == M_S32) || (mode_q == M_S64);
    sh_cur    = {3'd0, cnt_q} * 7'd7;
    sh_new    = sh_cur + 7'd7;
    acc_new   = acc_q | ({57'd0, payload} << sh_cur);
    // Shift amounts of 64 or more yield zero, so a full-length s64 gets no fill.
    fill      = {64{1'b1}} << sh_new;
    acc_ext   = (is_signed && payload[6]) ? (acc_new | fill) : acc_new;

    case (mode_q)
      M_U32:   result = {32'd0, acc_ext[31:0]};
      M_S32:   result = {{32{acc_ext[31]}}, acc_ext[31:0]};
      default: result = acc_ext;
    endcase

    err_new = E_OK;
    if (at_max) begin
      if (cont) begin
        err_new = E_LONG;
      end else begin
        case (mode_q)
          M_U32:   if (payload[6:4] != 3'b000) err_new = E_RANGE;
          M_S32:   if (payload[6:3] != 4'h0 && payload[6:3] != 4'hF) err_new = E_RANGE;
          M_U64:   if (payload[6:1] != 6'd0) err_new = E_RANGE;
          default: if (payload != 7'h00 && payload != 7'h7F) err_new = E_RANGE;
        endcase
      end
    end
  end

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    value_d  = value_q;
    length_d = length_q;
    error_d  = error_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_DECODE;
          mode_d  = mode;
          acc_d   = '0;
          cnt_d   = '0;
        end
      end
      S_DECODE: begin
        if (byte_valid) begin
          acc_d = acc_new;
          cnt_d = cnt_inc;
          if (!cont || at_max) begin
            state_d  = S_FINISH;
            value_d  = (err_new == E_OK) ? result : '0;
            length_d = cnt_inc;
            error_d  = err_new;
          end
        end
      end
      S_FINISH: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      mode_q   <= M_U32;
      acc_q    <= '0;
      cnt_q    <= '0;
      value_q  <= '0;
      length_q <= '0;
      error_q  <= E_OK;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      value_q  <= value_d;
      length_q <= length_d;
      error_q  <= error_d;
    end
  end

  assign byte_ready = (state_q == S_DECODE);
  assign busy       = (state_q == S_DECODE);
  assign done       = (state_q == S_FINISH);
  assign value      = value_q;
  assign length     = length_q;
  assign error      = error_q;

endmodule

// File: doc/leb128_decoder.md
# leb128_decoder

Sequential LEB128 immediate decoder on the instruction-fetch side of the `cpu` core. It sits between the ROM byte stream and the execute stage. It consumes one byte per accepted handshake and assembles varuint32, varint32, varint64 or varuint64 immediates into a 64-bit value, for example the operands of `i32.const`, `i64.const` and branch depths. It also flags encodings that are over-long or that carry out-of-range bits, so the core can raise a trap instead of executing a corrupt immediate.

## Interface

No parameters.

Ports:

- `clk` in 1: system clock, rising edge.
- `reset` in 1: asynchronous, active-low. Reset asserts when `reset`=0.
- `start` in 1: begin a decode. Sampled only in IDLE.
- `mode` in 2: encoding, latched on `start`.
  - 00 = u32
  - 01 = s32
  - 10 = s64
  - 11 = u64
- `byte_in` in 8: encoded byte. Bit 7 is the continuation flag, bits 6:0 are the payload.
- `byte_valid` in 1: `byte_in` is valid.
- `byte_ready` out 1: decoder accepts a byte this cycle.
- `busy` out 1: high in DECODE.
- `done` out 1: one-cycle pulse when the decode finishes, with or without error.
- `value` out 64: decoded value. Held until the next `start`.
- `length` out 4: number of bytes consumed, 1..10. Held until the next `start`.
- `error` out 2: result status, valid with `done` and held afterwards.
  - 0 = ok
  - 1 = too long
  - 2 = out-of-range bits

## Operation

**States**

- **IDLE**
  - `start`=1 → DECODE.
  - On entry to DECODE: latch `mode`, clear the accumulator, shift count and byte count.
- **DECODE**
  - `byte_ready`=1.
  - Each accepted byte (`byte_valid && byte_ready`) is handled as follows:
    - `acc |= payload << (7*n)`, truncated to 64 bits.
    - `n` increments.
    - Validity checks (below) are applied.
  - After a byte with continuation=0, or any error, the next state is FINISH.
- **FINISH**
  - `done`=1 for this one cycle; `value`, `length` and `error` are registered.
  - Next state is IDLE.

**Maximum length**

- 5 bytes for u32/s32; 10 bytes for s64/u64.
- If the byte at the maximum index has continuation=1, then `error`=1 and the decode ends at that byte.

**Final-byte range checks** (applied only at the maximum index)

- u32, byte 5: `byte_in[6:4]` must be 000.
- s32, byte 5: `byte_in[6:3]` must be 0000 or 1111.
- u64, byte 10: `byte_in[6:1]` must be 0.
- s64, byte 10: `byte_in[6:0]` must be 0x00 or 0x7F.
- Any violation gives `error`=2.

**Result forming**

- Signed modes: if the last payload bit 6 = 1 and 7*n < 64, fill `acc[63:7*n]` with ones.
- 32-bit modes: `value[63:32]` is the sign extension of `acc[31]` for s32, and zero for u32.
- On error, `value` = 0.

**Other rules**

- `start` outside IDLE is ignored. This includes the `start` cycle itself, while in FINISH.
- `byte_valid` in IDLE or FINISH is not accepted (`byte_ready`=0). The upstream holds the byte.
- Gaps in `byte_valid` during DECODE only stall the decode; the state is held.

## Timing

- **Reset values:** state = IDLE; `byte_ready`, `busy`, `done` = 0; `value` = 0; `length` = 0; `error` = 0.
- **Reset mid-decode:** the decode is abandoned immediately and no `done` is produced.
- **Start:** `start` at edge k puts the block in DECODE, with `byte_ready`=1, from cycle k+1.
- **Latency:**
  - The last byte is accepted at edge N, and `done`, `value`, `length` and `error` are valid in cycle N+1.
  - Minimum total from `start` to `done` is 3 cycles for a 1-byte immediate.
- **Throughput:** one byte per cycle while `byte_valid` stays high.
- **Back-to-back decodes:** `start` may be asserted in the cycle after `done` at the earliest. `byte_ready` is low during FINISH.
- **Simultaneous events:** `reset` asserted in the same cycle as a byte handshake wins, and the byte is discarded.

## Test plan

- **u32 multi-byte:** u32, bytes E5 8E 26 streamed back-to-back → `done` one cycle after 0x26; `value`=0x0000_0000_0009_8765, `length`=3, `error`=0.
- **s32 negative:**
  - s32, byte 7F → `value`=0xFFFF_FFFF_FFFF_FFFF, `length`=1.
  - s32, bytes C0 BB 78 → `value`=0xFFFF_FFFF_FFFE_1DC0, `length`=3.
- **s64 full length:** s64, bytes 80×9 then 7F → `value`=0x8000_0000_0000_0000, `length`=10, `error`=0.
- **u32 boundary:**
  - u32, FF FF FF FF 0F → `value`=0x0000_0000_FFFF_FFFF, `error`=0.
  - FF FF FF FF 1F → `error`=2, `value`=0.
  - FF FF FF FF FF → `error`=1, `length`=5, `byte_ready` low afterwards.
- **Stall, ignored start, reset:**
  - u32 E5 8E 26 with `byte_valid` dropped for 3 cycles between bytes, and `start` pulsed mid-decode → same result as the first scenario, `start` ignored.
  - Drive `reset`=0 after the second byte of a new decode → no `done`, all outputs 0, IDLE.
